rf_write_arbiter: RTL

Arbitrates the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (load-return / mul-div result path). The pipeline has priority. A starvation counter guarantees the long-latency unit a slot by stalling the writeback stage for one cycle. The block sits between the writeback stage and the register file and drives the registered write port.

---
 rtl/rf_write_arbiter_if.sv | 27 ++
 rtl/rf_write_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the writeback request, long-latency request and register-file write port.
// The master drives requests; the slave (the arbiter) drives handshakes and the write port.
interface rf_write_arbiter_if #(
    parameter int BW = 32
);
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [BW-1:0] wb_data;
    logic          wb_stall;
    logic          lu_valid;
    logic [4:0]    lu_rd;
    logic [BW-1:0] lu_data;
    logic          lu_ready;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [BW-1:0] rf_wdata;

    modport master (
        output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
        input  wb_stall, lu_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
        output wb_stall, lu_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the writeback stage has priority, and the long-latency unit
// is forced through after STARVE_LIMIT consecutive denied cycles by stalling writeback once.
//
// state | meaning
// PIPE  | writeback has priority; lu only gets the port when there is no pipeline write
// FORCE | single-cycle slot reserved for lu; writeback is stalled
module rf_write_arbiter #(
    parameter int BW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

    typedef enum logic [0:0] {
        PIPE  = 1'b0,
        FORCE = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [4:0]    waddr_q;
    logic [BW-1:0] wdata_q;

    logic pipe_wr;
    logic pipe_gnt;
    logic lu_gnt;
    logic lu_ready_c;
    logic wb_stall_c;

    assign pipe_wr = bus.wb_valid && (bus.wb_rd != 5'd0);

    // Handshakes are held low throughout reset, not just after the state is cleared.
    always_comb begin
        lu_ready_c = 1'b0;
        wb_stall_c = 1'b0;
        if (rst) begin
            if (state == FORCE) begin
                lu_ready_c = 1'b1;
                wb_stall_c = 1'b1;
            end else begin
                lu_ready_c = !pipe_wr;
            end
        end
    end

    assign pipe_gnt = (state == PIPE) && pipe_wr;
    assign lu_gnt   = bus.lu_valid && lu_ready_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= PIPE;
            cnt     <= '0;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (pipe_gnt) begin
                we_q    <= 1'b1;
                waddr_q <= bus.wb_rd;
                wdata_q <= bus.wb_data;
            end else if (lu_gnt) begin
                we_q    <= (bus.lu_rd != 5'd0);
                waddr_q <= bus.lu_rd;
                wdata_q <= bus.lu_data;
            end

            case (state)
                PIPE: begin
                    if (bus.lu_valid && !lu_ready_c) begin
                        if (cnt == CNT_LAST) begin
                            state <= FORCE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                FORCE: begin
                    state <= PIPE;
                    cnt   <= '0;
                end
                default: begin
                    state <= PIPE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.lu_ready = lu_ready_c;
    assign bus.wb_stall = wb_stall_c;
    assign bus.rf_we    = we_q;
    assign bus.rf_waddr = waddr_q;
    assign bus.rf_wdata = wdata_q;
endmodule
